// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared defaults and state encoding for the data-memory port arbiter.
package dmem_arb_pkg;
    localparam int AW_DEF       = 8;
    localparam int DW_DEF       = 32;
    localparam int MAX_WAIT_DEF = 8;
    localparam int CW           = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } arb_state_e;
endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// dmem_arb_wait_cnt: saturating debug-wait counter with clear/increment and a hit flag at MAX_WAIT.
module dmem_arb_wait_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    assign hit_o = cnt_q == CW'(MAX_WAIT);

    always_comb cnt_d = clr_i ? '0 : (inc_i && !hit_o) ? cnt_q + CW'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data memory between the MEM stage (priority) and a debug/loader port.
// Define DMEM_PORT_ARBITER_STEAL_EN to let a starved debug request steal one cycle by stalling the pipeline.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_en,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_addr,
    input  logic [DW-1:0] pipe_wdata,
    output logic [DW-1:0] pipe_rdata,
    output logic          pipe_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_spo
);
`ifdef DMEM_PORT_ARBITER_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    arb_state_e    state_q, state_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          grant, steal, hit, cnt_clr, cnt_inc;

    // The counter tracks WAIT cycles handed to the pipeline; it is zero on entry to WAIT.
    dmem_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .hit_o (hit)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        steal   = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: if (dbg_req) begin
                grant   = !pipe_en;
                state_d = pipe_en ? WAIT : ACK;
            end
            WAIT: if (!dbg_req) begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end else if (!pipe_en || (STEAL_EN && hit)) begin
                grant   = 1'b1;
                steal   = pipe_en;
                state_d = ACK;
            end else begin
                cnt_inc = 1'b1;
            end
            ACK: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb dbg_rdata_d = grant ? mem_spo : dbg_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign mem_a      = grant ? dbg_addr : pipe_addr;
    assign mem_d      = grant ? dbg_wdata : pipe_wdata;
    assign mem_we     = rst_n && (grant ? dbg_we : pipe_en && pipe_we);
    assign pipe_rdata = mem_spo;
    assign pipe_stall = STEAL_EN && steal;
    assign dbg_ack    = state_q == ACK;
    assign dbg_rdata  = dbg_rdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vectors with a per-cycle expectation queue checked by a negedge monitor.
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pipe_en = 1'b0, pipe_we = 1'b0;
  logic [7:0]  pipe_addr = '0;
  logic [31:0] pipe_wdata = '0;
  logic [31:0] pipe_rdata;
  logic        pipe_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [7:0]  mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic [31:0] mem_spo;
  logic [31:0] mem [256] = '{default: 32'h0};
  typedef struct {
    int          id;
    logic [7:0]  a;
    logic        we, st, ack, cr;
    logic [31:0] rd;
  } exp_t;
  exp_t exp_q[$];
  int   n_vec = 0, n_bad = 0, vid = 0;
  always #5 clk = ~clk;
  assign mem_spo = mem[mem_a];
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;
  dmem_port_arbiter #(.AW(8), .DW(32), .MAX_WAIT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_en    (pipe_en),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_rdata (pipe_rdata),
    .pipe_stall (pipe_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_ack    (dbg_ack),
    .dbg_rdata  (dbg_rdata),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .mem_we     (mem_we),
    .mem_spo    (mem_spo)
  );
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (pipe_stall !== e.st || dbg_ack !== e.ack) begin
        n_bad++;
        $display("FAIL vec %0d handshake: got stall=%b ack=%b, want stall=%b ack=%b",
                 e.id, pipe_stall, dbg_ack, e.st, e.ack);
      end
      if (mem_a !== e.a || mem_we !== e.we || (e.cr && dbg_rdata !== e.rd) || pipe_rdata !== mem_spo) begin
        n_bad++;
        $display("FAIL vec %0d datapath: got a=%h we=%b rd=%h, want a=%h we=%b rd=%h (rd checked=%b)",
                 e.id, mem_a, mem_we, dbg_rdata, e.a, e.we, e.rd, e.cr);
      end
    end
  end
  task automatic vec(input logic rn, pe, pw, input logic [7:0] pa, input logic [31:0] pd,
                     input logic dr, dw, input logic [7:0] da, input logic [31:0] dd,
                     input logic [7:0] ea, input logic ewe, est, eack, ecr, input logic [31:0] erd);
    @(posedge clk);
    #1;
    rst_n = rn; pipe_en = pe; pipe_we = pw; pipe_addr = pa; pipe_wdata = pd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    exp_q.push_back('{vid, ea, ewe, est, eack, ecr, erd});
    vid++;
  endtask
  initial begin
    rst_n = 1'b0;
    vec(0, 1, 1, 8'h07, 32'h1, 0, 0, 8'h00, 32'h0, 8'h07, 0, 0, 0, 1, 32'h0);
    vec(1, 0, 0, 8'h00, 32'h0, 1, 1, 8'h10, 32'hDEADBEEF, 8'h10, 1, 0, 0, 1, 32'h0);
    vec(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0,        8'h00, 0, 0, 1, 1, 32'h0);
    vec(1, 0, 0, 8'h00, 32'h0, 1, 0, 8'h10, 32'h0,        8'h10, 0, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0,        8'h00, 0, 0, 1, 1, 32'hDEADBEEF);
    vec(1, 1, 1, 8'h20, 32'hA5A50020, 0, 0, 8'h00, 32'h0, 8'h20, 1, 0, 0, 0, 32'h0);
    vec(1, 1, 0, 8'h01, 32'h0, 1, 0, 8'h20, 32'h0, 8'h01, 0, 0, 0, 0, 32'h0);
    vec(1, 1, 0, 8'h02, 32'h0, 1, 0, 8'h20, 32'h0, 8'h02, 0, 0, 0, 0, 32'h0);
    vec(1, 1, 0, 8'h03, 32'h0, 1, 0, 8'h20, 32'h0, 8'h03, 0, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h04, 32'h0, 1, 0, 8'h20, 32'h0, 8'h20, 0, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h04, 32'h0, 0, 0, 8'h00, 32'h0, 8'h04, 0, 0, 1, 1, 32'hA5A50020);
    vec(1, 1, 1, 8'h41, 32'h11111111, 1, 1, 8'h40, 32'hCAFEF00D, 8'h41, 1, 0, 0, 0, 32'h0);
    vec(1, 1, 1, 8'h41, 32'h11111111, 1, 1, 8'h40, 32'hCAFEF00D, 8'h41, 1, 0, 0, 0, 32'h0);
    vec(1, 1, 1, 8'h41, 32'h11111111, 1, 1, 8'h40, 32'hCAFEF00D, 8'h41, 1, 0, 0, 0, 32'h0);
`ifdef DMEM_PORT_ARBITER_STEAL_EN
    vec(1, 1, 1, 8'h41, 32'h11111111, 1, 1, 8'h40, 32'hCAFEF00D, 8'h40, 1, 1, 0, 0, 32'h0);
    vec(1, 1, 1, 8'h41, 32'h11111111, 0, 0, 8'h00, 32'h0,        8'h41, 1, 0, 1, 1, 32'h0);
`else
    for (int i = 3; i < 50; i++)
      vec(1, 1, 1, 8'h41, 32'h11111111, 1, 1, 8'h40, 32'hCAFEF00D, 8'h41, 1, 0, 0, 0, 32'h0);
    vec(1, 0, 1, 8'h41, 32'h11111111, 1, 1, 8'h40, 32'hCAFEF00D, 8'h40, 1, 0, 0, 0, 32'h0);
    vec(1, 0, 1, 8'h41, 32'h11111111, 0, 0, 8'h00, 32'h0,        8'h41, 0, 0, 1, 1, 32'h0);
`endif
    vec(1, 0, 0, 8'h00, 32'h0, 1, 0, 8'h40, 32'h0, 8'h40, 0, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 8'h00, 0, 0, 1, 1, 32'hCAFEF00D);
    vec(1, 1, 1, 8'h05, 32'h0BADCAFE, 1, 0, 8'h05, 32'h0, 8'h05, 1, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h06, 32'h0,        1, 0, 8'h05, 32'h0, 8'h05, 0, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h06, 32'h0,        0, 0, 8'h00, 32'h0, 8'h06, 0, 0, 1, 1, 32'h0BADCAFE);
    vec(1, 1, 0, 8'h51, 32'h0, 1, 1, 8'h50, 32'h55, 8'h51, 0, 0, 0, 0, 32'h0);
    vec(1, 1, 0, 8'h51, 32'h0, 0, 0, 8'h00, 32'h0,  8'h51, 0, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h52, 32'h0, 0, 0, 8'h00, 32'h0,  8'h52, 0, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h52, 32'h0, 1, 0, 8'h50, 32'h0,  8'h50, 0, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h52, 32'h0, 0, 0, 8'h00, 32'h0,  8'h52, 0, 0, 1, 1, 32'h0);
    vec(1, 1, 0, 8'h31, 32'h0, 1, 1, 8'h30, 32'h12345678, 8'h31, 0, 0, 0, 0, 32'h0);
    vec(1, 1, 0, 8'h31, 32'h0, 1, 1, 8'h30, 32'h12345678, 8'h31, 0, 0, 0, 0, 32'h0);
    vec(0, 1, 0, 8'h31, 32'h0, 1, 1, 8'h30, 32'h12345678, 8'h31, 0, 0, 0, 1, 32'h0);
    vec(1, 0, 0, 8'h32, 32'h0, 0, 0, 8'h00, 32'h0,        8'h32, 0, 0, 0, 1, 32'h0);
    vec(1, 0, 0, 8'h32, 32'h0, 1, 0, 8'h30, 32'h0,        8'h30, 0, 0, 0, 0, 32'h0);
    vec(1, 0, 0, 8'h32, 32'h0, 0, 0, 8'h00, 32'h0,        8'h32, 0, 0, 1, 1, 32'h0);
    @(posedge clk);
    #1;
    if (n_vec != vid || n_bad != 0) $display("FAIL summary: %0d of %0d vectors checked, %0d miscompares", n_vec, vid, n_bad);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
